// File: rtl/wallace_pkg.sv
// Shared helpers for the Wallace-tree multiplier: row-height bookkeeping for the
// carry-save reduction tree and the Baugh-Wooley correction constant.
package wallace_pkg;

  typedef enum logic {
    MODE_UNSIGNED = 1'b0,
    MODE_SIGNED   = 1'b1
  } mode_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Row count after k layers of 3:2 compression (leftover rows pass through).
  function automatic int unsigned rows_after(input int unsigned h0, input int unsigned k);
    int unsigned h;
    h = h0;
    for (int unsigned i = 0; i < k; i++) begin
      if (h > 2) h = 2 * (h / 3) + h % 3;
    end
    return h;
  endfunction

  function automatic int unsigned layers_to(input int unsigned h0, input int unsigned target);
    int unsigned h;
    int unsigned n;
    h = h0;
    n = 0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (h > target) begin
        h = 2 * (h / 3) + h % 3;
        n++;
      end
    end
    return n;
  endfunction

  function automatic logic [63:0] bw_const(input int unsigned width);
    return (64'd1 << width) | (64'd1 << (2 * width - 1));
  endfunction

endpackage

// File: rtl/csa_layer.sv
// One carry-save reduction layer: every group of three rows becomes a sum row and
// a left-shifted carry row; up to two leftover rows pass straight through.
module csa_layer #(
  parameter int ROWS = 3,
  parameter int COLS = 8
) (
  input  logic [ROWS*COLS-1:0]                   in_rows,
  output logic [(2*(ROWS/3)+ROWS%3)*COLS-1:0]    out_rows
);

  localparam int GROUPS = ROWS / 3;
  localparam int REM    = ROWS % 3;

  for (genvar g = 0; g < GROUPS; g++) begin : g_fa
    logic [COLS-1:0] a, b, c;
    logic [COLS-2:0] maj;
    assign a   = in_rows[(3*g)*COLS   +: COLS];
    assign b   = in_rows[(3*g+1)*COLS +: COLS];
    assign c   = in_rows[(3*g+2)*COLS +: COLS];
    // Carry out of the top column falls outside the 2*WIDTH result and is dropped.
    assign maj = (a[COLS-2:0] & b[COLS-2:0]) | (a[COLS-2:0] & c[COLS-2:0]) |
                 (b[COLS-2:0] & c[COLS-2:0]);
    assign out_rows[(2*g)*COLS   +: COLS] = a ^ b ^ c;
    assign out_rows[(2*g+1)*COLS +: COLS] = {maj, 1'b0};
  end

  for (genvar r = 0; r < REM; r++) begin : g_pass
    assign out_rows[(2*GROUPS+r)*COLS +: COLS] = in_rows[(3*GROUPS+r)*COLS +: COLS];
  end

endmodule

// File: rtl/wallace_mult_pipe.sv
// Three-stage stallable Wallace-tree multiplier: S1 partial products + early
// reduction, S2 reduction to two rows, S3 carry-propagate add into the output.
module wallace_mult_pipe
  import wallace_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int unsigned COLS  = 2 * WIDTH;
  localparam int unsigned H0    = WIDTH + 1;
  localparam int unsigned H1_T  = (WIDTH + 1) / 2 + 1;
  localparam int unsigned L1    = layers_to(H0, H1_T);
  localparam int unsigned H1    = rows_after(H0, L1);
  localparam int unsigned L2    = layers_to(H1, 2);
  localparam logic [63:0] BW_ALL = bw_const(WIDTH);

  mode_e mode;
  logic  v1, v2, v3;
  logic  adv1, adv2, adv3;
  logic  [H0*COLS-1:0] pp_flat;
  logic  [H1*COLS-1:0] s1_rows;
  logic  [TAG_W-1:0]   s1_tag, s2_tag;
  logic  [COLS-1:0]    s2_sum, s2_carry;

  assign mode      = mode_e'(in_signed);
  assign adv3      = !v3 || out_ready;
  assign adv2      = !v2 || adv3;
  assign adv1      = !v1 || adv2;
  assign in_ready  = adv1;
  assign out_valid = v3;

  // Baugh-Wooley: invert the MSB row/column terms except the MSB*MSB corner,
  // and add the correction constant as an extra row.
  always_comb begin
    pp_flat = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      for (int unsigned j = 0; j < WIDTH; j++) begin
        pp_flat[i*COLS + i + j] = (in_a[j] & in_b[i]) ^
          ((mode == MODE_SIGNED) && ((i == WIDTH - 1) != (j == WIDTH - 1)));
      end
    end
    pp_flat[WIDTH*COLS +: COLS] = (mode == MODE_SIGNED) ? BW_ALL[COLS-1:0] : '0;
  end

  for (genvar k = 0; k < L1; k++) begin : g_l1
    localparam int unsigned HI = rows_after(H0, k);
    localparam int unsigned HO = rows_after(H0, k + 1);
    logic [HI*COLS-1:0] li;
    logic [HO*COLS-1:0] lo;
    if (k == 0) begin : g_src
      assign li = pp_flat;
    end else begin : g_src
      assign li = g_l1[k-1].lo;
    end
    csa_layer #(.ROWS(HI), .COLS(COLS)) u_csa (.in_rows(li), .out_rows(lo));
  end

  for (genvar k = 0; k < L2; k++) begin : g_l2
    localparam int unsigned HI = rows_after(H1, k);
    localparam int unsigned HO = rows_after(H1, k + 1);
    logic [HI*COLS-1:0] li;
    logic [HO*COLS-1:0] lo;
    if (k == 0) begin : g_src
      assign li = s1_rows;
    end else begin : g_src
      assign li = g_l2[k-1].lo;
    end
    csa_layer #(.ROWS(HI), .COLS(COLS)) u_csa (.in_rows(li), .out_rows(lo));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      v3          <= 1'b0;
      out_product <= '0;
      out_tag     <= '0;
    end else begin
      if (adv1) v1 <= in_valid;
      if (adv2) v2 <= v1;
      if (adv3) v3 <= v2;
      if (adv3 && v2) begin
        out_product <= s2_sum + s2_carry;
        out_tag     <= s2_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_rows <= g_l1[L1-1].lo;
      s1_tag  <= in_tag;
    end
    if (adv2 && v1) begin
      s2_sum   <= g_l2[L2-1].lo[0 +: COLS];
      s2_carry <= g_l2[L2-1].lo[COLS +: COLS];
      s2_tag   <= s1_tag;
    end
  end

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Directed and randomised checks of wallace_mult_pipe at WIDTH=16, TAG_W=4.
module tb_wallace_mult_pipe;

  typedef struct packed {
    logic [31:0] p;
    logic [3:0]  t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_signed, out_valid, out_ready;
  logic [15:0] in_a, in_b;
  logic [3:0]  in_tag, out_tag;
  logic [31:0] out_product;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0, failures = 0;
  int   ov_cnt = 0, run = 0, max_run = 0;
  bit   rand_bp = 0;

  always #5 clk = ~clk;

  wallace_mult_pipe #(.WIDTH(16), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_tag(out_tag)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      ov_cnt++;
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("product", out_product, mon_e.p);
        check("tag", out_tag, mon_e.t);
      end
    end
  end

  always @(posedge clk) begin
    if (rand_bp) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic put(input logic [15:0] a, input logic [15:0] b, input logic s,
                     input logic [3:0] t, input logic [31:0] p, output int waited);
    in_a = a; in_b = b; in_signed = s; in_tag = t; in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 40) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      in_valid = 1'b0;
      check("accept_timeout", 0, 1);
    end else begin
      exp_q.push_back('{p: p, t: t});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    in_valid = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int cnt0;
    logic [15:0] ra, rb;
    logic signed [15:0] sa, sb;
    logic signed [31:0] sp;
    logic rs;
    logic [31:0] rp;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_signed = 1'b0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_product", out_product, 0);
    check("rst_out_tag", out_tag, 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);

    // Latency and unsigned corner.
    put(16'hFFFF, 16'hFFFF, 1'b0, 4'd5, 32'hFFFE0001, w);
    in_valid = 1'b0;
    @(negedge clk); check("lat_c1", out_valid, 0);
    @(negedge clk); check("lat_c2", out_valid, 0);
    @(negedge clk); check("lat_c3", out_valid, 1);
    drain("drain_lat");

    // Mixed-mode back-to-back.
    put(16'hFFFF, 16'hFFFF, 1'b1, 4'd1, 32'h00000001, w); check("mix_w0", w, 0);
    put(16'h8000, 16'h0001, 1'b0, 4'd2, 32'h00008000, w); check("mix_w1", w, 0);
    put(16'h8000, 16'h0001, 1'b1, 4'd3, 32'hFFFF8000, w); check("mix_w2", w, 0);
    put(16'h8000, 16'h0001, 1'b0, 4'd4, 32'h00008000, w); check("mix_w3", w, 0);
    put(16'h8000, 16'h8000, 1'b1, 4'd6, 32'h40000000, w); check("mix_w4", w, 0);
    drain("drain_mix");

    // Throughput: eight beats with no stall and eight consecutive results.
    max_run = 0;
    for (int i = 0; i < 8; i++) begin
      put(16'(i + 1), 16'h0101, 1'b0, 4'(i), 32'((i + 1) * 257), w);
      check("tp_no_stall", w, 0);
    end
    drain("drain_tp");
    check("tp_run", max_run, 8);

    // Backpressure: three slots fill, then input stalls and output holds.
    out_ready = 1'b0;
    put(16'd3,   16'd5,   1'b0, 4'd1, 32'd15,    w); check("bp_w0", w, 0);
    put(16'd7,   16'd9,   1'b0, 4'd2, 32'd63,    w); check("bp_w1", w, 0);
    put(16'd100, 16'd200, 1'b0, 4'd3, 32'd20000, w); check("bp_w2", w, 0);
    in_a = 16'h1234; in_b = 16'h0010; in_signed = 1'b0; in_tag = 4'd4; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_hold_product", out_product, 15);
      check("bp_hold_tag", out_tag, 1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    put(16'h1234, 16'h0010, 1'b0, 4'd4, 32'h00012340, w); check("bp_pop_accept", w, 0);
    put(16'hFFFF, 16'h0001, 1'b0, 4'd5, 32'h0000FFFF, w); check("bp_pop_accept2", w, 0);
    drain("drain_bp");

    // Bubble collapse: two beats held with a free slot remaining.
    out_ready = 1'b0;
    put(16'd2, 16'd3, 1'b0, 4'd6, 32'd6, w);
    idle(1);
    put(16'd4, 16'd5, 1'b0, 4'd7, 32'd20, w);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bub_in_ready", in_ready, 1);
    end
    check("bub_out_valid", out_valid, 1);
    check("bub_hold", out_product, 6);
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain("drain_bub");

    // Reset while three beats are in flight.
    put(16'd11, 16'd11, 1'b0, 4'd8,  32'd121, w);
    put(16'd12, 16'd12, 1'b0, 4'd9,  32'd144, w);
    put(16'd13, 16'd13, 1'b0, 4'd10, 32'd169, w);
    in_valid = 1'b0;
    check("rst_pre_ov", out_valid, 1);
    #2 rst_n = 1'b0;
    #1 check("rst_async_ov", out_valid, 0);
    exp_q.delete();
    cnt0 = ov_cnt;
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("rst_no_out", ov_cnt - cnt0, 0);
    check("rst_in_ready_after", in_ready, 1);

    // Random sweep with random gaps and random backpressure.
    rand_bp = 1;
    for (int i = 0; i < 10000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      sa = ra;
      sb = rb;
      sp = sa * sb;
      rp = rs ? sp : ({16'd0, ra} * {16'd0, rb});
      put(ra, rb, rs, 4'($urandom_range(0, 15)), rp, w);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    rand_bp = 0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain("drain_rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
